// File: rtl/aes_key_expand_server_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_key_expand_server_pkg
// Description : Shared constants, round-count encodings and GF(2^8) helpers
//               for the AES round-key expansion server.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_key_expand_server_pkg;

    // Round-key store depth in 32-bit words: 4 * (14 + 1)
    localparam int STORE_WORDS   = 60;
    // Longest supported cipher key in words (AES-256)
    localparam int KEY_WORDS_MAX = 8;
    // Bit position of the valid flag on the Key output
    localparam int KEY_VALID_BIT = 128;

    // Supported round counts; each one selects a key length Nk
    typedef enum logic [3:0] {
        NR_AES128 = 4'd10,
        NR_AES192 = 4'd12,
        NR_AES256 = 4'd14
    } nr_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply, shift-and-add
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse (x^254, 0 maps to 0) then affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] inv;
        r = x;
        for (int k = 0; k < 6; k++) begin
            r = gf_mul(gf_mul(r, r), x);
        end
        inv = gf_mul(r, r);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // RotWord with byte 0 at the LSB: bytes [a0,a1,a2,a3] -> [a1,a2,a3,a0]
    function automatic logic [31:0] rot_word(input logic [31:0] t);
        return {t[7:0], t[31:8]};
    endfunction

    function automatic logic nr_supported(input logic [3:0] nr);
        return (nr == NR_AES128) || (nr == NR_AES192) || (nr == NR_AES256);
    endfunction

    // Key length in words for a supported round count
    function automatic logic [3:0] nk_of(input logic [3:0] nr);
        logic [3:0] nk;
        case (nr)
            NR_AES128: nk = 4'd4;
            NR_AES192: nk = 4'd6;
            default:   nk = 4'd8;
        endcase
        return nk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_expand_server_subword.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_subword
// Description : SubWord - four parallel AES S-boxes over one 32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_subword
    import aes_key_expand_server_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    generate
        for (genvar b = 0; b < 4; b++) begin : g_sbox
            assign word_out[8*b +: 8] = sbox(word_in[8*b +: 8]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/aes_key_expand_server.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_key_expand_server
// Description : Word-serial AES-128/192/256 key expansion into a 60-word
//               round-key store, with a combinational {valid, round key}
//               read port addressed by round number.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expand_server
    import aes_key_expand_server_pkg::*;
#(
    parameter int WORDS_MAX = STORE_WORDS,
    parameter int NK_MAX    = KEY_WORDS_MAX
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [255:0] Cipher_key,
    input  logic [3:0]   Nr,
    input  logic [3:0]   Addr,
    output logic [128:0] Key,
    output logic         Key_Busy,
    output logic         Key_Err
);

    // Round-key store; contents are meaningless until words_done covers them
    logic [31:0] store_q [WORDS_MAX];
    logic [31:0] store_d [WORDS_MAX];

    logic [5:0]  i_q, i_d;                   // next word index to write
    logic [5:0]  words_done_q, words_done_d; // count of valid words in store
    logic [2:0]  j_q, j_d;                   // i mod Nk
    logic [7:0]  rcon_q, rcon_d;
    logic [3:0]  nr_q, nr_d;
    logic [3:0]  nk_q, nk_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic [5:0]  idx_prev;
    logic [5:0]  idx_back;
    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp_word;
    logic        is_rcon_step;
    logic        is_sub_step;
    logic [3:0]  nk_new;

    // Two read taps for the recurrence: w[i-1] and w[i-Nk]
    assign idx_prev  = i_q - 6'd1;
    assign idx_back  = i_q - {2'b00, nk_q};
    assign prev_word = store_q[idx_prev];
    assign back_word = store_q[idx_back];

    // j==0 is the RotWord/SubWord/Rcon step; AES-256 also substitutes at j==4
    assign is_rcon_step = (j_q == 3'd0);
    assign is_sub_step  = (nk_q == 4'd8) && (j_q == 3'd4);
    assign sub_in       = is_rcon_step ? rot_word(prev_word) : prev_word;
    assign nk_new       = nk_of(Nr);

    aes_subword u_subword (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    assign temp_word = is_rcon_step ? (sub_out ^ {24'h000000, rcon_q}) :
                       is_sub_step  ? sub_out : prev_word;

    // Next-state: a load always wins, otherwise produce one word per busy cycle
    always_comb begin
        store_d      = store_q;
        i_d          = i_q;
        words_done_d = words_done_q;
        j_d          = j_q;
        rcon_d       = rcon_q;
        nr_d         = nr_q;
        nk_d         = nk_q;
        busy_d       = busy_q;
        err_d        = err_q;
        if (key_load) begin
            if (nr_supported(Nr)) begin
                for (int c = 0; c < NK_MAX; c++) begin
                    if (c < int'(nk_new)) store_d[c] = Cipher_key[32*c +: 32];
                end
                words_done_d = {2'b00, nk_new};
                i_d          = {2'b00, nk_new};
                j_d          = 3'd0;
                rcon_d       = 8'h01;
                nr_d         = Nr;
                nk_d         = nk_new;
                busy_d       = 1'b1;
                err_d        = 1'b0;
            end else begin
                words_done_d = 6'd0;
                busy_d       = 1'b0;
                err_d        = 1'b1;
            end
        end else if (busy_q) begin
            store_d[i_q] = back_word ^ temp_word;
            i_d          = i_q + 6'd1;
            words_done_d = words_done_q + 6'd1;
            j_d          = (j_q == (nk_q[2:0] - 3'd1)) ? 3'd0 : j_q + 3'd1;
            if (is_rcon_step) rcon_d = xtime(rcon_q);
            // Last word of the schedule is w[4*Nr+3]
            if (i_q == {nr_q, 2'b11}) busy_d = 1'b0;
        end
    end

    // Control registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q          <= 6'd0;
            words_done_q <= 6'd0;
            j_q          <= 3'd0;
            rcon_q       <= 8'h01;
            nr_q         <= 4'd0;
            nk_q         <= 4'd4;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            i_q          <= i_d;
            words_done_q <= words_done_d;
            j_q          <= j_d;
            rcon_q       <= rcon_d;
            nr_q         <= nr_d;
            nk_q         <= nk_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    // Store array; no reset needed since validity is tracked by words_done
    always_ff @(posedge clk) begin
        store_q <= store_d;
    end

    logic        key_valid;
    logic [5:0]  rd_base;
    logic [127:0] key_data;

    assign rd_base = {Addr, 2'b00};

    // Round-key read: valid once all four words of round Addr exist
    always_comb begin
        key_valid = (Addr <= nr_q) && ({Addr, 2'b11} < words_done_q);
        key_data  = '0;
        if (key_valid) begin
            for (int c = 0; c < 4; c++) begin
                key_data[32*c +: 32] = store_q[rd_base + 6'(c)];
            end
        end
    end

    assign Key[KEY_VALID_BIT]       = key_valid;
    assign Key[KEY_VALID_BIT-1:0]   = key_data;
    assign Key_Busy                 = busy_q;
    assign Key_Err                  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand_server.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_expand_server
// Description : Self-checking bench for aes_key_expand_server: FIPS-197
//               vectors, streaming/reload/reset sequences and random keys
//               against a byte-level key-schedule model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand_server;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_load = 1'b0;
    logic [255:0] Cipher_key = '0;
    logic [3:0]   Nr = 4'd0;
    logic [3:0]   Addr = 4'd0;
    logic [128:0] Key;
    logic         Key_Busy;
    logic         Key_Err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    aes_key_expand_server dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_load   (key_load),
        .Cipher_key (Cipher_key),
        .Nr         (Nr),
        .Addr       (Addr),
        .Key        (Key),
        .Key_Busy   (Key_Busy),
        .Key_Err    (Key_Err)
    );

    // ---------------- reference model ----------------
    logic [7:0] sb [256];
    logic [7:0] mw [60][4];   // w[i] as FIPS byte array
    int         m_nr = 0;
    int         m_nk = 4;
    int         m_k = 0;      // clock edges since the last valid load
    logic       m_loaded = 1'b0;
    logic       m_err = 1'b0;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: search for the inverse, then FIPS affine bits
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] cst;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int n = 0; n < 8; n++) begin
                s[n] = inv[n] ^ inv[(n+4)%8] ^ inv[(n+5)%8] ^ inv[(n+6)%8]
                     ^ inv[(n+7)%8] ^ cst[n];
            end
            sb[x] = s;
        end
    endtask

    task automatic model_load(input logic [255:0] key, input int nr);
        logic [7:0] t [4];
        logic [7:0] tmp;
        logic [7:0] rc [10];
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        m_nr = nr;
        m_nk = nr - 6;
        for (int c = 0; c < m_nk; c++)
            for (int b = 0; b < 4; b++) mw[c][b] = key[8*(4*c+b) +: 8];
        for (int i = m_nk; i < 4*(nr+1); i++) begin
            for (int b = 0; b < 4; b++) t[b] = mw[i-1][b];
            if (i % m_nk == 0) begin
                tmp  = t[0];
                t[0] = sb[t[1]] ^ rc[i/m_nk - 1];
                t[1] = sb[t[2]];
                t[2] = sb[t[3]];
                t[3] = sb[tmp];
            end else if (m_nk > 6 && i % m_nk == 4) begin
                for (int b = 0; b < 4; b++) t[b] = sb[t[b]];
            end
            for (int b = 0; b < 4; b++) mw[i][b] = mw[i-m_nk][b] ^ t[b];
        end
        m_k      = 0;
        m_loaded = 1'b1;
        m_err    = 1'b0;
    endtask

    function automatic int model_words();
        int full;
        full = 4*m_nr + 4;
        if (!m_loaded) return 0;
        return (m_nk + m_k < full) ? m_nk + m_k : full;
    endfunction

    function automatic logic model_busy();
        return m_loaded && (m_nk + m_k < 4*m_nr + 4);
    endfunction

    function automatic logic [128:0] model_key(input int a);
        logic         v;
        logic [127:0] d;
        d = '0;
        v = m_loaded && (a <= m_nr) && (4*a + 3 < model_words());
        if (v)
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < 4; b++) d[32*c + 8*b +: 8] = mw[4*a+c][b];
        return {v, d};
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [255:0] fips_to_lsb(input logic [255:0] x, input int nbytes);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < nbytes; k++) r[8*k +: 8] = x[8*(nbytes-1-k) +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [130:0] got, input logic [130:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_all(input string name);
        check(name, {Key, Key_Busy, Key_Err},
              {model_key(int'(Addr)), model_busy(), m_err});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_k++;
    endtask

    task automatic set_addr(input int a);
        Addr = 4'(a);
        #1;
    endtask

    task automatic do_load(input logic [255:0] key, input int nr);
        Cipher_key = key;
        Nr         = 4'(nr);
        key_load   = 1'b1;
        @(posedge clk);
        #1;
        key_load = 1'b0;
        if (nr == 10 || nr == 12 || nr == 14) begin
            model_load(key, nr);
        end else begin
            m_loaded = 1'b0;
            m_err    = 1'b1;
        end
    endtask

    // Bounded wait for Key_Busy low; returns edges elapsed since the load
    task automatic wait_done(output int lat);
        lat = 0;
        while (Key_Busy && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    typedef struct {
        int           nr;
        logic [255:0] key_fips;
        int           addr;
        logic [127:0] mask;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    vec_t vecs [5];
    int   lat;
    int   nr_r;

    initial begin
        vecs[0] = '{10, K128, 10, {128{1'b1}}, 128'ha60c63b6c80c3fe18925eec9a8f914d0, 40};
        vecs[1] = '{10, K128, 1,  {128{1'b1}}, 128'h05766c2a3939a323b12c548817fefaa0, 40};
        vecs[2] = '{10, K128, 0,  {128{1'b1}}, 128'h3c4fcf098815f7aba6d2ae2816157e2b, 40};
        vecs[3] = '{12, K192, 12, {{32{1'b1}}, 96'h0}, {32'h02220001, 96'h0}, 46};
        vecs[4] = '{14, K256, 14, {{32{1'b1}}, 96'h0}, {32'h1e636c70, 96'h0}, 52};

        build_sbox();

        // Reset state
        tick();
        tick();
        check("reset_outputs", {Key, Key_Busy, Key_Err}, 131'h0);
        rst_n = 1'b1;
        tick();
        set_addr(0);
        check("after_reset_release", {Key, Key_Busy, Key_Err}, 131'h0);

        // FIPS-197 vectors: latency to done and selected round keys
        for (int v = 0; v < 5; v++) begin
            do_load(fips_to_lsb(vecs[v].key_fips, 4*(vecs[v].nr - 6)), vecs[v].nr);
            wait_done(lat);
            check($sformatf("latency_v%0d", v), 131'(lat), 131'(vecs[v].lat));
            set_addr(vecs[v].addr);
            check($sformatf("fips_key_v%0d", v),
                  {2'b00, Key[128], Key[127:0] & vecs[v].mask},
                  {2'b00, 1'b1, vecs[v].exp});
            check_all($sformatf("model_v%0d", v));
        end

        // Streaming: Addr=0 valid immediately, Addr=1 valid 4 edges after load
        do_load(fips_to_lsb(K128, 16), 10);
        for (int k = 0; k < 7; k++) begin
            set_addr(0);
            check($sformatf("stream_a0_k%0d", k), 131'(Key[128]), 131'(1));
            set_addr(1);
            check($sformatf("stream_a1_k%0d", k), 131'(Key[128]), 131'(k >= 4));
            check_all($sformatf("stream_model_k%0d", k));
            tick();
        end
        wait_done(lat);

        // Reload during AES-256 expansion with the AES-128 key
        do_load(fips_to_lsb(K256, 32), 14);
        repeat (19) tick();
        set_addr(2);
        check("pre_reload_valid", 131'(Key[128]), 131'(1));
        do_load(fips_to_lsb(K128, 16), 10);
        set_addr(2);
        check("reload_valid_drop", 131'({Key[128], Key_Busy}), 131'(2'b01));
        wait_done(lat);
        check("reload_latency", 131'(lat), 131'(40));
        for (int a = 0; a < 16; a++) begin
            set_addr(a);
            check_all($sformatf("reload_sweep_a%0d", a));
        end
        set_addr(10);
        check("reload_round10", {2'b00, Key}, {2'b00, 1'b1, vecs[0].exp});

        // Unsupported Nr: error flag, nothing valid
        do_load(fips_to_lsb(K128, 16), 11);
        check("nr11_flags", 131'({Key_Busy, Key_Err}), 131'(2'b01));
        for (int a = 0; a < 16; a++) begin
            set_addr(a);
            check($sformatf("nr11_key_a%0d", a), {2'b00, Key}, 131'h0);
        end

        // Asynchronous reset in the middle of an expansion
        do_load(fips_to_lsb(K256, 32), 14);
        repeat (10) tick();
        set_addr(0);
        check("pre_reset_valid", 131'(Key[128]), 131'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {Key, Key_Busy, Key_Err}, 131'h0);
        m_loaded = 1'b0;
        m_err    = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_addr(k);
            check_all($sformatf("post_reset_k%0d", k));
            tick();
        end

        // Random keys and lengths, random Addr every cycle of the expansion
        for (int r = 0; r < 15; r++) begin
            logic [255:0] rk;
            for (int w = 0; w < 8; w++) rk[32*w +: 32] = $urandom;
            nr_r = 10 + 2 * int'($urandom_range(0, 2));
            do_load(rk, nr_r);
            for (int k = 0; k < 4*nr_r + 4 - (nr_r - 6) + 3; k++) begin
                set_addr(int'($urandom_range(0, 15)));
                check_all($sformatf("rand%0d_k%0d", r, k));
                tick();
            end
            for (int a = 0; a < 16; a++) begin
                set_addr(a);
                check_all($sformatf("rand%0d_sweep_a%0d", r, a));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
